// File: rtl/cascade_counter_pkg.sv
// Shared types and encodings for the cascade_counter slice.
package cascade_counter_pkg;

  localparam int DIGIT_WIDTH = 4;

  typedef logic [DIGIT_WIDTH-1:0] digit_t;

  localparam logic DIR_UP   = 1'b0;
  localparam logic DIR_DOWN = 1'b1;

endpackage

// File: rtl/cascade_counter_if.sv
// Control/data bundle between a cascade_counter and whoever drives it.
interface cascade_counter_if #(
  parameter int NUM_DIGITS  = 4,
  parameter int DIGIT_WIDTH = 4
);

  logic                              ENABLE_IN;
  logic                              DIR;
  logic                              LOAD;
  logic [NUM_DIGITS*DIGIT_WIDTH-1:0] LOAD_VALUE;
  logic [NUM_DIGITS*DIGIT_WIDTH-1:0] COUNT;
  logic [NUM_DIGITS-1:0]             CARRY_OUT;
  logic                              TRIG_OUT;

  modport master (
    output ENABLE_IN, DIR, LOAD, LOAD_VALUE,
    input  COUNT, CARRY_OUT, TRIG_OUT
  );

  modport slave (
    input  ENABLE_IN, DIR, LOAD, LOAD_VALUE,
    output COUNT, CARRY_OUT, TRIG_OUT
  );

endinterface

// File: rtl/cascade_counter_digit.sv
// One modulo-(DIGIT_MAX+1) up/down digit cell; load port exists only when
// CASCADE_COUNTER_LOAD_EN is defined.
module counter_digit
  import cascade_counter_pkg::*;
#(
  parameter int DIGIT_WIDTH = 4,
  parameter int DIGIT_MAX   = 9
) (
  input  logic                   CLK,
  input  logic                   RESET,
  input  logic                   step,
  input  logic                   dir,
`ifdef CASCADE_COUNTER_LOAD_EN
  input  logic                   load,
  input  logic [DIGIT_WIDTH-1:0] load_value,
`endif
  output logic [DIGIT_WIDTH-1:0] value,
  output logic                   is_terminal
);

  localparam logic [DIGIT_WIDTH-1:0] MAX_V = DIGIT_WIDTH'(DIGIT_MAX);

  always_comb is_terminal = (dir == DIR_DOWN) ? (value == '0) : (value == MAX_V);

`ifdef CASCADE_COUNTER_LOAD_EN
  logic [DIGIT_WIDTH-1:0] load_clamped;
  always_comb load_clamped = (load_value > MAX_V) ? MAX_V : load_value;
`endif

  // NOTE: state registers use non-blocking assignments so every digit samples
  // the pre-edge enable chain, giving one synchronous counter with no ripple.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      value <= (dir == DIR_DOWN) ? MAX_V : '0;
`ifdef CASCADE_COUNTER_LOAD_EN
    end else if (load) begin
      value <= load_clamped;
`endif
    end else if (step) begin
      if (dir == DIR_DOWN) value <= (value == '0)   ? MAX_V : value - 1'b1;
      else                 value <= (value == MAX_V) ? '0   : value + 1'b1;
    end
  end

endmodule

// File: rtl/cascade_counter.sv
// Multi-digit synchronous up/down counter built from counter_digit cells.
// Optional parallel load is compiled in with CASCADE_COUNTER_LOAD_EN.
module cascade_counter
  import cascade_counter_pkg::*;
#(
  parameter int NUM_DIGITS  = 4,
  parameter int DIGIT_WIDTH = 4,
  parameter int DIGIT_MAX   = 9,
  parameter bit SATURATE    = 1'b0
) (
  input logic              CLK,
  input logic              RESET,
  cascade_counter_if.slave bus
);

  logic [NUM_DIGITS:0]               prefix;
  logic [NUM_DIGITS-1:0]             term;
  logic [NUM_DIGITS-1:0]             step;
  logic [NUM_DIGITS-1:0]             carry_d;
  logic [NUM_DIGITS-1:0]             carry_q;
  logic [NUM_DIGITS*DIGIT_WIDTH-1:0] count;
  logic                              load_eff;
  logic                              hold;

`ifdef CASCADE_COUNTER_LOAD_EN
  assign load_eff = bus.LOAD;
`else
  assign load_eff = 1'b0;
`endif

  // prefix[i] is high when digits 0..i-1 all sit at their terminal value.
  assign prefix[0] = 1'b1;
  assign hold      = SATURATE && prefix[NUM_DIGITS];

  for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_digit
    assign prefix[g+1] = prefix[g] & term[g];
    assign step[g]     = bus.ENABLE_IN & prefix[g] & ~hold;

    counter_digit #(
      .DIGIT_WIDTH (DIGIT_WIDTH),
      .DIGIT_MAX   (DIGIT_MAX)
    ) u_digit (
      .CLK         (CLK),
      .RESET       (RESET),
      .step        (step[g]),
      .dir         (bus.DIR),
`ifdef CASCADE_COUNTER_LOAD_EN
      .load        (bus.LOAD),
      .load_value  (bus.LOAD_VALUE[g*DIGIT_WIDTH +: DIGIT_WIDTH]),
`endif
      .value       (count[g*DIGIT_WIDTH +: DIGIT_WIDTH]),
      .is_terminal (term[g])
    );
  end

  assign carry_d = {NUM_DIGITS{bus.ENABLE_IN & ~load_eff}} & prefix[NUM_DIGITS:1];

  always_ff @(posedge CLK) begin
    if (RESET) begin
      carry_q       <= '0;
      bus.TRIG_OUT  <= 1'b0;
    end else begin
      carry_q       <= carry_d;
      bus.TRIG_OUT  <= carry_d[NUM_DIGITS-1];
    end
  end

  assign bus.COUNT     = count;
  assign bus.CARRY_OUT = carry_q;

endmodule

// File: tb/tb_cascade_counter.sv
// Bench for cascade_counter: a wrap-mode and a saturate-mode instance share
// stimulus and are compared with an integer-valued model of the counter.
module tb_cascade_counter;
  import cascade_counter_pkg::*;

  localparam int ND   = 2;
  localparam int DW   = 4;
  localparam int DMAX = 9;
  localparam int TOP  = 99;

  logic CLK = 1'b0;
  logic RESET;
  always #5 CLK = ~CLK;

  cascade_counter_if #(.NUM_DIGITS(ND), .DIGIT_WIDTH(DW)) if0 ();
  cascade_counter_if #(.NUM_DIGITS(ND), .DIGIT_WIDTH(DW)) if1 ();

  cascade_counter #(.NUM_DIGITS(ND), .DIGIT_WIDTH(DW), .DIGIT_MAX(DMAX), .SATURATE(1'b0))
    dut0 (.CLK(CLK), .RESET(RESET), .bus(if0));
  cascade_counter #(.NUM_DIGITS(ND), .DIGIT_WIDTH(DW), .DIGIT_MAX(DMAX), .SATURATE(1'b1))
    dut1 (.CLK(CLK), .RESET(RESET), .bus(if1));

  int checks   = 0;
  int failures = 0;

  int         m0, m1;
  logic [1:0] ec0, ec1;

  function automatic logic [7:0] to_bcd(input int n);
    digit_t hi, lo;
    hi = 4'(n / 10);
    lo = 4'(n % 10);
    return {hi, lo};
  endfunction

  // Counter as a plain integer 0..99; carries from decimal remainders.
  function automatic void model_step(input int n, input bit sat, input bit rst,
                                     input bit en, input bit dir, input bit ld,
                                     input logic [7:0] lv,
                                     output int nn, output logic [1:0] cy);
    int d0, d1;
    nn = n;
    cy = 2'b00;
    if (rst) begin
      nn = dir ? TOP : 0;
`ifdef CASCADE_COUNTER_LOAD_EN
    end else if (ld) begin
      d0 = int'(lv[3:0]); if (d0 > DMAX) d0 = DMAX;
      d1 = int'(lv[7:4]); if (d1 > DMAX) d1 = DMAX;
      nn = d1 * 10 + d0;
`endif
    end else if (en) begin
      cy[0] = dir ? (n % 10 == 0) : (n % 10 == 9);
      cy[1] = dir ? (n == 0)      : (n == TOP);
      if (cy[1] && sat) nn = n;
      else              nn = dir ? (n + TOP) % (TOP + 1) : (n + 1) % (TOP + 1);
    end
  endfunction

  task automatic drive(input bit rst, input bit en, input bit dir, input bit ld,
                       input logic [7:0] lv);
    int n0, n1;
    logic [1:0] c0, c1;
    RESET = rst;
    if0.ENABLE_IN = en; if0.DIR = dir; if0.LOAD = ld; if0.LOAD_VALUE = lv;
    if1.ENABLE_IN = en; if1.DIR = dir; if1.LOAD = ld; if1.LOAD_VALUE = lv;
    model_step(m0, 1'b0, rst, en, dir, ld, lv, n0, c0);
    model_step(m1, 1'b1, rst, en, dir, ld, lv, n1, c1);
    @(posedge CLK);
    #1;
    m0 = n0; ec0 = c0;
    m1 = n1; ec1 = c1;
  endtask

  task automatic test_reset();
    drive(1, 0, 0, 0, 8'h00);
    checks++; if (if0.COUNT !== 8'h00) begin failures++; $display("FAIL reset_up_count got=%h exp=00", if0.COUNT); end
    checks++; if (if0.TRIG_OUT !== 1'b0) begin failures++; $display("FAIL reset_up_trig got=%b exp=0", if0.TRIG_OUT); end
    checks++; if (if0.CARRY_OUT !== 2'b00) begin failures++; $display("FAIL reset_up_carry got=%b exp=00", if0.CARRY_OUT); end
    drive(1, 0, 1, 0, 8'h00);
    checks++; if (if0.COUNT !== 8'h99) begin failures++; $display("FAIL reset_down_count got=%h exp=99", if0.COUNT); end
    checks++; if (if1.COUNT !== 8'h99) begin failures++; $display("FAIL reset_down_count_sat got=%h exp=99", if1.COUNT); end
  endtask

  task automatic test_count_up();
    drive(1, 0, 0, 0, 8'h00);
    for (int i = 1; i <= 100; i++) begin
      drive(0, 1, 0, 0, 8'h00);
      checks++; if (if0.COUNT !== to_bcd(m0)) begin failures++; $display("FAIL up_count step=%0d got=%h exp=%h", i, if0.COUNT, to_bcd(m0)); end
      checks++; if (if0.CARRY_OUT !== ec0) begin failures++; $display("FAIL up_carry step=%0d got=%b exp=%b", i, if0.CARRY_OUT, ec0); end
      if (i == 10) begin
        checks++; if (if0.COUNT !== 8'h10 || if0.CARRY_OUT !== 2'b01) begin
          failures++; $display("FAIL up_09_to_10 got=%h/%b exp=10/01", if0.COUNT, if0.CARRY_OUT); end
      end
      if (i == 99) begin
        checks++; if (if0.COUNT !== 8'h99 || if0.TRIG_OUT !== 1'b0) begin
          failures++; $display("FAIL up_reach_99 got=%h/%b exp=99/0", if0.COUNT, if0.TRIG_OUT); end
      end
    end
    checks++; if (if0.COUNT !== 8'h00 || if0.TRIG_OUT !== 1'b1) begin
      failures++; $display("FAIL up_wrap got=%h/%b exp=00/1", if0.COUNT, if0.TRIG_OUT); end
    drive(0, 0, 0, 0, 8'h00);
    checks++; if (if0.TRIG_OUT !== 1'b0 || if0.COUNT !== 8'h00) begin
      failures++; $display("FAIL up_trig_one_cycle got=%h/%b exp=00/0", if0.COUNT, if0.TRIG_OUT); end
  endtask

  task automatic test_load();
`ifdef CASCADE_COUNTER_LOAD_EN
    drive(0, 0, 0, 1, 8'h00);
    checks++; if (if0.COUNT !== 8'h00) begin failures++; $display("FAIL load_00 got=%h exp=00", if0.COUNT); end
    drive(0, 1, 1, 0, 8'h00);
    checks++; if (if0.COUNT !== 8'h99 || if0.TRIG_OUT !== 1'b1) begin
      failures++; $display("FAIL down_wrap got=%h/%b exp=99/1", if0.COUNT, if0.TRIG_OUT); end
    drive(0, 1, 0, 1, 8'h47);
    checks++; if (if0.COUNT !== 8'h47 || if0.CARRY_OUT !== 2'b00) begin
      failures++; $display("FAIL load_over_enable got=%h/%b exp=47/00", if0.COUNT, if0.CARRY_OUT); end
    drive(0, 1, 0, 1, 8'h4C);
    checks++; if (if0.COUNT !== 8'h49) begin failures++; $display("FAIL load_clamp got=%h exp=49", if0.COUNT); end
`else
    drive(1, 0, 0, 0, 8'h00);
    drive(0, 1, 0, 1, 8'h47);
    checks++; if (if0.COUNT !== 8'h01) begin failures++; $display("FAIL load_ignored got=%h exp=01", if0.COUNT); end
`endif
  endtask

  task automatic test_saturate();
    drive(1, 0, 0, 0, 8'h00);
    for (int i = 0; i < 99; i++) drive(0, 1, 0, 0, 8'h00);
    checks++; if (if1.COUNT !== 8'h99) begin failures++; $display("FAIL sat_reach_99 got=%h exp=99", if1.COUNT); end
    for (int i = 0; i < 5; i++) begin
      drive(0, 1, 0, 0, 8'h00);
      checks++; if (if1.COUNT !== 8'h99 || if1.TRIG_OUT !== 1'b1) begin
        failures++; $display("FAIL sat_hold step=%0d got=%h/%b exp=99/1", i, if1.COUNT, if1.TRIG_OUT); end
      checks++; if (if0.COUNT !== to_bcd(m0)) begin
        failures++; $display("FAIL sat_wrap_peer step=%0d got=%h exp=%h", i, if0.COUNT, to_bcd(m0)); end
    end
    drive(0, 0, 0, 0, 8'h00);
    checks++; if (if1.TRIG_OUT !== 1'b0 || if1.COUNT !== 8'h99) begin
      failures++; $display("FAIL sat_disable got=%h/%b exp=99/0", if1.COUNT, if1.TRIG_OUT); end
  endtask

  task automatic test_dir_toggle();
    logic [7:0] exp_seq [3];
    exp_seq = '{8'h38, 8'h37, 8'h38};
    drive(1, 0, 0, 0, 8'h00);
    for (int i = 0; i < 37; i++) drive(0, 1, 0, 0, 8'h00);
    checks++; if (if0.COUNT !== 8'h37) begin failures++; $display("FAIL toggle_start got=%h exp=37", if0.COUNT); end
    for (int i = 0; i < 3; i++) begin
      drive(0, 1, i[0], 0, 8'h00);
      checks++; if (if0.COUNT !== exp_seq[i]) begin
        failures++; $display("FAIL toggle_seq step=%0d got=%h exp=%h", i, if0.COUNT, exp_seq[i]); end
    end
    drive(0, 1, 0, 0, 8'h00);
    drive(1, 1, 0, 0, 8'h00);
    checks++; if (if0.COUNT !== 8'h00 || if0.CARRY_OUT !== 2'b00 || if0.TRIG_OUT !== 1'b0) begin
      failures++; $display("FAIL mid_reset got=%h/%b/%b exp=00/00/0", if0.COUNT, if0.CARRY_OUT, if0.TRIG_OUT); end
  endtask

  task automatic test_random();
    bit rst, en, dir, ld;
    logic [7:0] lv;
    drive(1, 0, 0, 0, 8'h00);
    for (int i = 0; i < 400; i++) begin
      rst = ($urandom_range(0, 31) == 0);
      en  = ($urandom_range(0, 3) != 0);
      dir = ($urandom_range(0, 5) == 0) ? ~if0.DIR : if0.DIR;
      ld  = ($urandom_range(0, 9) == 0);
      lv  = 8'($urandom_range(0, 255));
      drive(rst, en, dir, ld, lv);
      checks++; if (if0.COUNT !== to_bcd(m0) || if0.CARRY_OUT !== ec0 || if0.TRIG_OUT !== ec0[1]) begin
        failures++; $display("FAIL rand_wrap i=%0d got=%h/%b/%b exp=%h/%b/%b", i,
          if0.COUNT, if0.CARRY_OUT, if0.TRIG_OUT, to_bcd(m0), ec0, ec0[1]); end
      checks++; if (if1.COUNT !== to_bcd(m1) || if1.CARRY_OUT !== ec1 || if1.TRIG_OUT !== ec1[1]) begin
        failures++; $display("FAIL rand_sat i=%0d got=%h/%b/%b exp=%h/%b/%b", i,
          if1.COUNT, if1.CARRY_OUT, if1.TRIG_OUT, to_bcd(m1), ec1, ec1[1]); end
    end
  endtask

  initial begin
    m0 = 0; m1 = 0; ec0 = 2'b00; ec1 = 2'b00;
    test_reset();
    test_count_up();
    test_load();
    test_saturate();
    test_dir_toggle();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/cascade_counter.md
# cascade_counter

Parameterised multi-digit synchronous up/down counter built from a chain of identical modulo-N digit cells. It supports wrap or saturate mode, parallel load and per-digit carry outputs. It replaces hand-chained single-digit counters in display and timing paths such as stopwatch, decimal display drivers and clock dividers. All digits advance as one synchronous counter, with no ripple between clock edges.

## Interface
- NUM_DIGITS, 4, number of cascaded digits (≥1)
- DIGIT_WIDTH, 4, bits per digit
- DIGIT_MAX, 9, terminal value of each digit when counting up (≤ 2^DIGIT_WIDTH−1)
- SATURATE, 0, 0 = wrap at terminal value, 1 = hold at terminal value
- CLK  input  1  clock, rising edge
- RESET  input  1  synchronous, active-high reset
- ENABLE_IN  input  1  count enable for the least-significant digit
- DIR  input  1  0 = count up, 1 = count down; sampled every cycle
- LOAD  input  1  parallel load strobe
- LOAD_VALUE  input  NUM_DIGITS*DIGIT_WIDTH  load data, digit 0 in LSBs
- COUNT  output  NUM_DIGITS*DIGIT_WIDTH  current count, digit 0 in LSBs
- CARRY_OUT  output  NUM_DIGITS  registered per-digit carry/borrow pulse
- TRIG_OUT  output  1  registered whole-counter terminal pulse

## Operation
- Terminal value per digit is DIGIT_MAX when DIR=0 and 0 when DIR=1.
- Digit i steps when ENABLE_IN=1 and digits 0..i−1 are all at terminal. This is a combinational enable chain evaluated in the same cycle.
- Step up: a digit at DIGIT_MAX goes to 0, otherwise it increments. Step down: a digit at 0 goes to DIGIT_MAX, otherwise it decrements.
- All-terminal means every digit is at its terminal value.
- SATURATE=1: when all-terminal and ENABLE_IN=1, COUNT holds. Individual digits still wrap while the counter is not all-terminal.
- Priority per cycle is RESET, then LOAD, then ENABLE_IN. LOAD with ENABLE_IN loads and does not count.
- Load clamp: any loaded digit above DIGIT_MAX is stored as DIGIT_MAX.
- A DIR change takes effect on the same cycle it is sampled. There is no pipeline and no hidden state.
- CARRY_OUT[i] is registered. It is 1 the cycle after ENABLE_IN=1 with digits 0..i all at terminal, with no RESET and no LOAD in that cycle.
- TRIG_OUT equals the registered value of CARRY_OUT[NUM_DIGITS−1]. In SATURATE=1 it therefore stays high on every cycle following an enabled cycle spent at all-terminal.
- Arithmetic is per digit, modulo DIGIT_MAX+1, in DIGIT_WIDTH bits. No binary carry ever crosses digit fields.

## Timing
- Reset with DIR=0 in the reset cycle: COUNT=0. Reset with DIR=1: every digit is DIGIT_MAX.
- Reset values: CARRY_OUT=0 and TRIG_OUT=0.
- COUNT updates on the edge that samples ENABLE_IN or LOAD, a 1-cycle latency.
- CARRY_OUT and TRIG_OUT go high on the same edge that produces the wrap value, for exactly one cycle per wrap in wrap mode.
- RESET mid-count takes effect on the next edge and discards any pending pulse.
- ENABLE_IN=0 holds COUNT and forces CARRY_OUT and TRIG_OUT to 0 on the next edge.

## Configuration
- CASCADE_COUNTER_LOAD_EN defined: LOAD and LOAD_VALUE work as described above.
- Macro undefined: the ports remain but are ignored, and the load mux and clamp logic are not generated. Priority becomes RESET, then ENABLE_IN.

## Structure
- Shared package cascade_counter_pkg holds the digit_t typedef (logic [DIGIT_WIDTH-1:0]) and the localparams for the DIR encoding, DIR_UP=0 and DIR_DOWN=1.
- Sub-module counter_digit is one modulo-N digit cell. Its inputs are step, DIR, load, load value and reset. Its outputs are the value and an is_terminal flag.
- The top level instantiates counter_digit NUM_DIGITS times with a generate loop and builds the enable chain, saturate gating and output registers.

## Test plan
All scenarios use NUM_DIGITS=2, DIGIT_MAX=9.
- RESET with DIR=0 gives COUNT=0x00 and TRIG_OUT=0. RESET with DIR=1 gives COUNT=0x99.
- From 0x00, DIR=0, 99 enables give 0x99. The 100th enable gives 0x00 with TRIG_OUT=1 for 1 cycle. CARRY_OUT[0] pulses at 0x09→0x10.
- LOAD 0x00 then DIR=1 with one enable gives COUNT=0x99 and TRIG_OUT=1 for 1 cycle.
- LOAD=1 with ENABLE_IN=1 and LOAD_VALUE=0x47 gives 0x47, not 0x48. LOAD_VALUE=0x4C gives 0x49 (clamped).
- SATURATE=1, count to 0x99, then 5 more enables: COUNT stays 0x99 and TRIG_OUT stays 1. Dropping ENABLE_IN drives TRIG_OUT to 0 next cycle.
- From 0x37, toggle DIR every cycle under enable: the sequence is 0x38, 0x37, 0x38. RESET mid-sequence gives 0x00 on the next edge with no trailing pulse.
